// File: rtl/imem_loader_pkg.sv
// Shared constants and state encoding for the boot-time instruction-memory loader.
package imem_loader_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned HDR_BYTES      = 4;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE = 3'd0;
    localparam state_t S_HDR  = 3'd1;
    localparam state_t S_DATA = 3'd2;
    localparam state_t S_CSUM = 3'd3;
    localparam state_t S_DONE = 3'd4;

    // States in which the loader consumes stream bytes.
    function automatic logic is_stream_state(input state_t s);
        return (s == S_HDR) || (s == S_DATA) || (s == S_CSUM);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface imem_loader_if #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32
);
    logic                     byte_valid;
    logic [7:0]               byte_data;
    logic                     byte_ready;
    logic                     wr_en;
    logic [ADDRESS_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0]    wr_data;

    // Loader side: consumes the stream, drives memory writes.
    modport master (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );

    // Environment side: byte source plus instruction memory.
    modport slave (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Packs accepted bytes little-endian into 32-bit words; the completing byte
// produces a combinational word_valid_c pulse with the assembled word_c.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_data,
    output logic        word_valid_c,
    output logic [31:0] word_c
);

    localparam int unsigned         LANE_W    = $clog2(BYTES_PER_WORD);
    localparam logic [LANE_W-1:0]   LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);

    logic [LANE_W-1:0] lane;
    logic [31:0]       shreg;

    // Newest byte enters at the top, so after four bytes the register reads {b3,b2,b1,b0}.
    assign word_c       = {byte_data, shreg[31:8]};
    assign word_valid_c = byte_en && (lane == LAST_LANE);

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            lane  <= '0;
            shreg <= '0;
        end else if (byte_en) begin
            lane  <= lane + LANE_W'(1);
            shreg <= word_c;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: header word count, then N little-endian words written to instruction memory.
// Optional trailing checksum word enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned              ADDRESS_WIDTH = 32,
    parameter int unsigned              DATA_WIDTH    = 32,
    parameter int unsigned              MEM_WORDS     = 256,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    imem_loader_if.master        bus,
    output logic                 cpu_hold,
    output logic                 done,
    output logic                 err
);

    localparam int unsigned CNT_W = 8 * HDR_BYTES;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t POST_DATA = S_CSUM;
`else
    localparam state_t POST_DATA = S_DONE;
`endif

    state_t                   state;
    state_t                   state_nxt;
    logic [CNT_W-1:0]         word_cnt;
    logic [CNT_W-1:0]         word_cnt_nxt;
    logic [CNT_W-1:0]         word_idx;
    logic [CNT_W-1:0]         word_idx_nxt;
    logic                     byte_ready_nxt;
    logic                     wr_en_nxt;
    logic [ADDRESS_WIDTH-1:0] wr_addr_nxt;
    logic [DATA_WIDTH-1:0]    wr_data_nxt;
    logic                     err_nxt;
    logic                     pk_clear;
    logic                     byte_en;
    logic                     word_valid_c;
    logic [31:0]              word_c;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]              csum;
    logic [31:0]              csum_nxt;
`endif

    assign byte_en = bus.byte_valid && bus.byte_ready;

    byte_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .clear        (pk_clear),
        .byte_en      (byte_en),
        .byte_data    (bus.byte_data),
        .word_valid_c (word_valid_c),
        .word_c       (word_c)
    );

    // Next-state and next-output decode.
    always_comb begin
        state_nxt    = state;
        word_cnt_nxt = word_cnt;
        word_idx_nxt = word_idx;
        wr_en_nxt    = 1'b0;
        wr_addr_nxt  = bus.wr_addr;
        wr_data_nxt  = bus.wr_data;
        err_nxt      = err;
        pk_clear     = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_nxt     = csum;
`endif

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt    = S_HDR;
                    err_nxt      = 1'b0;
                    pk_clear     = 1'b1;
                    word_idx_nxt = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_nxt     = '0;
`endif
                end
            end
            S_HDR: begin
                if (word_valid_c) begin
                    word_cnt_nxt = CNT_W'(word_c);
                    word_idx_nxt = '0;
                    state_nxt    = (word_c == 32'd0) ? POST_DATA : S_DATA;
                end
            end
            S_DATA: begin
                // One quiet cycle after the final word so the last write lands before release.
                if (word_idx == word_cnt) begin
                    state_nxt = POST_DATA;
                end else if (word_valid_c) begin
                    word_idx_nxt = word_idx + CNT_W'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_nxt     = csum + word_c;
`endif
                    if (word_idx < CNT_W'(MEM_WORDS)) begin
                        wr_en_nxt   = 1'b1;
                        wr_addr_nxt = BASE_ADDR + ADDRESS_WIDTH'({word_idx, 2'b00});
                        wr_data_nxt = DATA_WIDTH'(word_c);
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (word_valid_c) begin
                    if (word_c != csum) begin
                        err_nxt = 1'b1;
                    end
                    state_nxt = S_DONE;
                end
            end
`endif
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        byte_ready_nxt = is_stream_state(state_nxt) &&
                         !((state_nxt == S_DATA) && (word_idx_nxt == word_cnt_nxt));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Registered datapath and outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            word_cnt       <= '0;
            word_idx       <= '0;
            bus.byte_ready <= 1'b0;
            bus.wr_en      <= 1'b0;
            bus.wr_addr    <= BASE_ADDR;
            bus.wr_data    <= '0;
            cpu_hold       <= 1'b1;
            done           <= 1'b0;
            err            <= 1'b0;
        end else begin
            word_cnt       <= word_cnt_nxt;
            word_idx       <= word_idx_nxt;
            bus.byte_ready <= byte_ready_nxt;
            bus.wr_en      <= wr_en_nxt;
            bus.wr_addr    <= wr_addr_nxt;
            bus.wr_data    <= wr_data_nxt;
            cpu_hold       <= (state_nxt != S_DONE);
            done           <= (state_nxt == S_DONE);
            err            <= err_nxt;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            csum <= '0;
        end else begin
            csum <= csum_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a load-level reference model.
module tb_imem_loader;

    localparam int unsigned MEM_WORDS = 2;
    localparam logic [31:0] BASE      = 32'h0000_0000;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    logic start;
    logic cpu_hold;
    logic done;
    logic err;

    imem_loader_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus ();

    imem_loader #(
        .ADDRESS_WIDTH (32),
        .DATA_WIDTH    (32),
        .MEM_WORDS     (MEM_WORDS),
        .BASE_ADDR     (BASE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int          gap_mode = 0;
    logic [31:0] img [0:7];
    logic [31:0] wq_addr [$];
    logic [31:0] wq_data [$];
    int          dbl_pulse = 0;
    logic        wr_prev   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Write monitor: every strobed word lands in the capture queues.
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            wq_addr.push_back(bus.wr_addr);
            wq_data.push_back(bus.wr_data);
            if (wr_prev) dbl_pulse++;
        end
        wr_prev = (bus.wr_en === 1'b1);
    end

    // Called at a falling edge; returns at the falling edge after the byte was taken.
    task automatic send_byte(input logic [7:0] b);
        int g;
        int waited;
        g = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
        bus.byte_valid = 1'b0;
        repeat (g) @(negedge clk);
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        waited = 0;
        while (bus.byte_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (bus.byte_ready !== 1'b1) begin
            check("byte_ready_timeout", 32'(bus.byte_ready), 32'd1);
            bus.byte_valid = 1'b0;
            return;
        end
        @(negedge clk);
        bus.byte_valid = 1'b0;
    endtask

    task automatic run_load(input int n, input bit bad_csum, input bit collide, input bit mid_start);
        logic [31:0] nw;
        logic [31:0] sum;
        logic [31:0] cs;
        logic [31:0] w;
        int          exp_wr;
        int          extra;
        bit          last_data;
        bit          exp_err;
        @(negedge clk);
        wq_addr.delete();
        wq_data.delete();
        nw  = 32'(n);
        sum = 32'd0;
        start = 1'b1;
        if (collide) begin
            bus.byte_valid = 1'b1;
            bus.byte_data  = 8'hA5;
        end
        @(negedge clk);
        start = 1'b0;
        bus.byte_valid = 1'b0;
        check("ready_after_start", 32'(bus.byte_ready), 32'd1);
        check("err_clear_on_start", 32'(err), 32'd0);
        check("hold_during_load", 32'(cpu_hold), 32'd1);
        for (int i = 0; i < 4; i++) begin
            if (mid_start && i == 2) start = 1'b1;
            send_byte(nw[8*i +: 8]);
            start = 1'b0;
        end
        for (int k = 0; k < n; k++) begin
            w = img[k];
            for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
            sum = sum + w;
        end
        last_data = (n != 0);
        if (CSUM_EN) begin
            cs = bad_csum ? sum + 32'd1 : sum;
            for (int i = 0; i < 4; i++) send_byte(cs[8*i +: 8]);
            last_data = 1'b0;
        end
        extra = 0;
        while (done !== 1'b1 && extra < 8) begin
            @(negedge clk);
            extra++;
        end
        #1;
        exp_wr  = (n < int'(MEM_WORDS)) ? n : int'(MEM_WORDS);
        exp_err = (n > int'(MEM_WORDS)) || (CSUM_EN && bad_csum);
        check("done_latency", 32'(extra), last_data ? 32'd1 : 32'd0);
        check("wr_count", 32'(wq_addr.size()), 32'(exp_wr));
        for (int k = 0; k < exp_wr && k < wq_addr.size(); k++) begin
            check("wr_addr", wq_addr[k], BASE + 32'(4 * k));
            check("wr_data", wq_data[k], img[k]);
        end
        check("err", 32'(err), 32'(exp_err));
        check("done", 32'(done), 32'd1);
        check("cpu_hold_released", 32'(cpu_hold), 32'd0);
        check("byte_ready_in_done", 32'(bus.byte_ready), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] nw;
        logic [31:0] w;
        rst   = 1'b0;
        start = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_byte_ready", 32'(bus.byte_ready), 32'd0);
        check("rst_wr_en", 32'(bus.wr_en), 32'd0);
        check("rst_wr_addr", bus.wr_addr, BASE);
        check("rst_wr_data", bus.wr_data, 32'd0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b1;

        // Two-instruction image.
        img[0] = 32'h0010_0513;
        img[1] = 32'h0020_0593;
        run_load(2, 1'b0, 1'b0, 1'b0);

        // Empty image.
        run_load(0, 1'b0, 1'b0, 1'b0);

        // Overflow past MEM_WORDS.
        for (int k = 0; k < 3; k++) img[k] = $urandom;
        run_load(3, 1'b0, 1'b0, 1'b0);

        // Valid toggling every cycle.
        gap_mode = 1;
        img[0] = $urandom;
        run_load(1, 1'b0, 1'b0, 1'b0);
        gap_mode = 0;

        // Reset after 6 of 8 bytes, then reload.
        @(negedge clk);
        wq_addr.delete();
        wq_data.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nw = 32'd1;
        w  = $urandom;
        for (int i = 0; i < 4; i++) send_byte(nw[8*i +: 8]);
        for (int i = 0; i < 2; i++) send_byte(w[8*i +: 8]);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("midrst_cpu_hold", 32'(cpu_hold), 32'd1);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_byte_ready", 32'(bus.byte_ready), 32'd0);
        check("midrst_wr_addr", bus.wr_addr, BASE);
        repeat (3) @(negedge clk);
        check("midrst_no_write", 32'(wq_addr.size()), 32'd0);
        check("midrst_idle_ready", 32'(bus.byte_ready), 32'd0);
        img[0] = $urandom;
        run_load(1, 1'b0, 1'b0, 1'b0);

        // Checksum cases: 0x13 with checksum 0x14 (bad), then 0x13 (good).
        img[0] = 32'h0000_0013;
        run_load(1, 1'b1, 1'b0, 1'b0);
        run_load(1, 1'b0, 1'b0, 1'b0);

        // Randomized loads with stalls, start collisions and ignored mid-load starts.
        for (int t = 0; t < 14; t++) begin
            for (int k = 0; k < 8; k++) img[k] = $urandom;
            gap_mode = int'($urandom_range(0, 2));
            run_load(int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        gap_mode = 0;

        check("single_cycle_wr_en", 32'(dbl_pulse), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
